// File: rtl/handshake_pkg.sv
// Shared definitions for the handshake constant checker.
//   OCC_EMPTY / OCC_ONE / OCC_FULL : occupancy encoding of the 2-slot token buffer
//   sat_inc                        : saturating increment on a 64-bit carrier
package handshake_pkg;

   localparam int unsigned OCC_WIDTH = 2;

   localparam logic [OCC_WIDTH-1:0] OCC_EMPTY = 2'd0;
   localparam logic [OCC_WIDTH-1:0] OCC_ONE   = 2'd1;
   localparam logic [OCC_WIDTH-1:0] OCC_FULL  = 2'd2;

   // Callers zero-extend into 64 bits and cast the result back to their width.
   function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                           input logic [63:0] max_value);
      return (value >= max_value) ? value : value + 64'd1;
   endfunction

endpackage

// File: rtl/handshake_ctrl_tbuf.sv
// Two-slot dataless elastic buffer; the occupancy counter is the whole buffer.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   ins_valid   : upstream token valid
//   ins_ready   : registered, buffer not full
//   outs_valid  : registered, buffer not empty
//   outs_ready  : downstream accepts a token
//   accept_c    : combinational, token taken this cycle
//   emit_c      : combinational, token handed out this cycle
module handshake_ctrl_tbuf
   import handshake_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic ins_valid,
   output logic ins_ready,
   output logic outs_valid,
   input  logic outs_ready,
   output logic accept_c,
   output logic emit_c
);

   logic [OCC_WIDTH-1:0] occ;
   logic [OCC_WIDTH-1:0] occ_cur;
   logic [OCC_WIDTH-1:0] occ_next;

   // Handshake events come only from registered ready/valid.
   always_comb begin
      accept_c = ins_valid & ins_ready;
      emit_c   = outs_valid & outs_ready;
   end

   // Next occupancy; the unreachable code 3 is folded onto FULL.
   always_comb begin
      occ_cur  = (occ == 2'd3) ? OCC_FULL : occ;
      occ_next = occ_cur;
      case (occ_cur)
         OCC_EMPTY: begin
            if (accept_c) occ_next = OCC_ONE;
         end
         OCC_ONE: begin
            if (accept_c && !emit_c)      occ_next = OCC_FULL;
            else if (!accept_c && emit_c) occ_next = OCC_EMPTY;
         end
         default: begin
            if (emit_c) occ_next = OCC_ONE;
         end
      endcase
   end

   // ready/valid are flops loaded from occ_next so they always agree with occ.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ        <= OCC_EMPTY;
         ins_ready  <= 1'b1;
         outs_valid <= 1'b0;
      end else begin
         occ        <= occ_next;
         ins_ready  <= (occ_next != OCC_FULL);
         outs_valid <= (occ_next != OCC_EMPTY);
      end
   end

endmodule

// File: rtl/handshake_ctrl_tbuf_check.sv


// File: rtl/handshake_const_check.sv
// Data-to-control endpoint: consumes data tokens, regenerates dataless control
// tokens through a 2-slot buffer and checks each token against EXPECTED.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   ins/ins_valid   : input data token / valid
//   ins_ready       : registered, token can be accepted
//   outs_valid      : registered, control token available
//   outs_ready      : downstream accepts the control token
//   mismatch        : sticky, some accepted token differed from EXPECTED
//   mismatch_count  : saturating count of mismatching tokens
//   token_count     : saturating count of accepted tokens
module handshake_const_check
   import handshake_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [31:0] EXPECTED   = 32'h03382DB2,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] ins,
   input  logic                  ins_valid,
   output logic                  ins_ready,
   output logic                  outs_valid,
   input  logic                  outs_ready,
   output logic                  mismatch,
   output logic [CNT_WIDTH-1:0]  mismatch_count,
   output logic [CNT_WIDTH-1:0]  token_count
);

   // Expected value zero-extended or truncated to the data width.
   localparam logic [DATA_WIDTH-1:0] EXP_VALUE = DATA_WIDTH'(EXPECTED);
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

   logic                 accept;
   logic                 emit;
   logic                 mismatch_next;
   logic [CNT_WIDTH-1:0] mismatch_count_next;
   logic [CNT_WIDTH-1:0] token_count_next;

   handshake_ctrl_tbuf u_tbuf (
      .clk        (clk),
      .rst        (rst),
      .ins_valid  (ins_valid),
      .ins_ready  (ins_ready),
      .outs_valid (outs_valid),
      .outs_ready (outs_ready),
      .accept_c   (accept),
      .emit_c     (emit)
   );

   // Status update on accept; ins is only looked at when a token is taken.
   always_comb begin
      mismatch_next       = mismatch;
      mismatch_count_next = mismatch_count;
      token_count_next    = token_count;
      if (accept) begin
         token_count_next = CNT_WIDTH'(sat_inc(64'(token_count), 64'(CNT_MAX)));
         if (ins != EXP_VALUE) begin
            mismatch_next       = 1'b1;
            mismatch_count_next = CNT_WIDTH'(sat_inc(64'(mismatch_count), 64'(CNT_MAX)));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mismatch       <= 1'b0;
         mismatch_count <= '0;
         token_count    <= '0;
      end else begin
         mismatch       <= mismatch_next;
         mismatch_count <= mismatch_count_next;
         token_count    <= token_count_next;
      end
   end

   // emit only matters inside the buffer; kept visible for debug probing.
   logic emit_unused;
   assign emit_unused = emit;

endmodule

// File: tb/tb_handshake_const_check.sv
// Self-checking bench for handshake_const_check: a default instance and a
// CNT_WIDTH=4 instance share all inputs; a token queue tracks pending control
// tokens and bench-side counters give the expected status.
module tb_handshake_const_check;

   localparam logic [31:0] EXP = 32'h03382DB2;

   logic        clk;
   logic        rst;
   logic [31:0] ins;
   logic        ins_valid;
   logic        outs_ready;

   logic        ins_ready, outs_valid, mismatch;
   logic [15:0] mismatch_count, token_count;
   logic        s_ins_ready, s_outs_valid, s_mismatch;
   logic [3:0]  s_mismatch_count, s_token_count;

   handshake_const_check dut (
      .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid),
      .ins_ready(ins_ready), .outs_valid(outs_valid), .outs_ready(outs_ready),
      .mismatch(mismatch), .mismatch_count(mismatch_count), .token_count(token_count)
   );

   handshake_const_check #(.CNT_WIDTH(4)) dut_sat (
      .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid),
      .ins_ready(s_ins_ready), .outs_valid(s_outs_valid), .outs_ready(outs_ready),
      .mismatch(s_mismatch), .mismatch_count(s_mismatch_count), .token_count(s_token_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks   = 0;
   int failures = 0;

   // Scoreboard: one entry per pending control token (its accept index).
   int tok_q[$];
   int m_acc_idx = 0;
   int m_tok = 0, m_mc = 0, m_tok4 = 0, m_mc4 = 0;
   bit m_mis = 0;
   int m_emits = 0;

   // Emits actually handed out by the default instance.
   int obs_emits = 0;
   always @(posedge clk)
      if (!rst && outs_valid && outs_ready) obs_emits <= obs_emits + 1;

   // Advance one cycle with current inputs and update the reference model.
   task automatic step();
      bit acc, em, bad;
      acc = !rst && ins_valid && (tok_q.size() < 2);
      em  = !rst && outs_ready && (tok_q.size() > 0);
      bad = (ins !== EXP);
      @(posedge clk);
      #1;
      if (rst) begin
         tok_q.delete();
         m_tok = 0; m_mc = 0; m_tok4 = 0; m_mc4 = 0; m_mis = 0;
      end else begin
         if (em) begin
            void'(tok_q.pop_front());
            m_emits++;
         end
         if (acc) begin
            tok_q.push_back(m_acc_idx);
            m_acc_idx++;
            if (m_tok < 65535) m_tok++;
            if (m_tok4 < 15) m_tok4++;
            if (bad) begin
               m_mis = 1;
               if (m_mc < 65535) m_mc++;
               if (m_mc4 < 15) m_mc4++;
            end
         end
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1; ins_valid = 1'b0; outs_ready = 1'b0;
      repeat (n) step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset(2);
      checks++; if (outs_valid !== 1'b0) begin failures++; $display("FAIL reset_outs_valid: got %b want 0", outs_valid); end
      checks++; if (ins_ready !== 1'b1) begin failures++; $display("FAIL reset_ins_ready: got %b want 1", ins_ready); end
      checks++; if (mismatch !== 1'b0) begin failures++; $display("FAIL reset_mismatch: got %b want 0", mismatch); end
      checks++; if (token_count !== 16'd0) begin failures++; $display("FAIL reset_token_count: got %0d want 0", token_count); end
      checks++; if (mismatch_count !== 16'd0) begin failures++; $display("FAIL reset_mismatch_count: got %0d want 0", mismatch_count); end
   endtask

   task automatic test_single();
      int e0;
      do_reset(1);
      e0 = obs_emits;
      ins = EXP; ins_valid = 1'b1; outs_ready = 1'b1;
      step();
      ins_valid = 1'b0;
      checks++; if (outs_valid !== 1'b1) begin failures++; $display("FAIL single_valid_next: got %b want 1", outs_valid); end
      checks++; if (token_count !== 16'(m_tok) || m_tok != 1) begin failures++; $display("FAIL single_token_count: got %0d want 1", token_count); end
      step();
      checks++; if (outs_valid !== 1'b0) begin failures++; $display("FAIL single_valid_drop: got %b want 0", outs_valid); end
      checks++; if (mismatch !== 1'b0) begin failures++; $display("FAIL single_mismatch: got %b want 0", mismatch); end
      checks++; if (obs_emits - e0 !== 1) begin failures++; $display("FAIL single_emits: got %0d want 1", obs_emits - e0); end
   endtask

   task automatic test_backpressure();
      int e0;
      do_reset(1);
      e0 = obs_emits;
      ins = EXP; ins_valid = 1'b1; outs_ready = 1'b0;
      repeat (4) step();
      checks++; if (token_count !== 16'd2) begin failures++; $display("FAIL bp_token_count: got %0d want 2", token_count); end
      checks++; if (ins_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready: got %b want 0", ins_ready); end
      ins_valid = 1'b0; outs_ready = 1'b1;
      step();
      checks++; if (outs_valid !== 1'b1 || ins_ready !== 1'b1) begin failures++; $display("FAIL bp_drain1: got valid=%b ready=%b want valid=1 ready=1", outs_valid, ins_ready); end
      step();
      checks++; if (outs_valid !== 1'b0 || ins_ready !== 1'b1) begin failures++; $display("FAIL bp_drain2: got valid=%b ready=%b want valid=0 ready=1", outs_valid, ins_ready); end
      checks++; if (obs_emits - e0 !== 2 || m_emits - obs_emits !== 0) begin failures++; $display("FAIL bp_emits: got %0d want 2", obs_emits - e0); end
      outs_ready = 1'b0;
   endtask

   task automatic test_stream();
      int e0, bad_cyc;
      do_reset(1);
      e0 = obs_emits; bad_cyc = 0;
      ins = EXP; ins_valid = 1'b1; outs_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         step();
         if (outs_valid !== 1'b1 || ins_ready !== 1'b1 || tok_q.size() != 1) bad_cyc++;
      end
      checks++; if (bad_cyc != 0) begin failures++; $display("FAIL stream_steady: got %0d bad cycles want 0", bad_cyc); end
      checks++; if (token_count !== 16'd100) begin failures++; $display("FAIL stream_token_count: got %0d want 100", token_count); end
      checks++; if (obs_emits - e0 !== 99) begin failures++; $display("FAIL stream_emits: got %0d want 99", obs_emits - e0); end
      ins_valid = 1'b0;
      step();
      outs_ready = 1'b0;
   endtask

   task automatic test_mismatch();
      logic [31:0] vals [4];
      int e0;
      vals[0] = EXP; vals[1] = 32'h0000_0000; vals[2] = EXP; vals[3] = 32'hFFFF_FFFF;
      do_reset(1);
      e0 = obs_emits;
      outs_ready = 1'b1; ins_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ins = vals[i];
         step();
         checks++;
         if (mismatch !== m_mis || mismatch !== (i >= 1)) begin
            failures++; $display("FAIL mm_sticky_%0d: got %b want %b", i, mismatch, (i >= 1));
         end
      end
      ins_valid = 1'b0;
      repeat (2) step();
      checks++; if (mismatch_count !== 16'd2) begin failures++; $display("FAIL mm_count: got %0d want 2", mismatch_count); end
      checks++; if (token_count !== 16'd4) begin failures++; $display("FAIL mm_token_count: got %0d want 4", token_count); end
      checks++; if (obs_emits - e0 !== 4) begin failures++; $display("FAIL mm_emits: got %0d want 4", obs_emits - e0); end
      checks++; if (mismatch !== 1'b1) begin failures++; $display("FAIL mm_hold: got %b want 1", mismatch); end
      outs_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int e0;
      do_reset(1);
      ins = 32'h1234_5678; ins_valid = 1'b1; outs_ready = 1'b0;
      repeat (3) step();
      checks++; if (ins_ready !== 1'b0 || mismatch !== 1'b1) begin failures++; $display("FAIL mid_setup: got ready=%b mismatch=%b want ready=0 mismatch=1", ins_ready, mismatch); end
      rst = 1'b1;
      step();
      rst = 1'b0; ins_valid = 1'b0;
      checks++; if (outs_valid !== 1'b0 || ins_ready !== 1'b1) begin failures++; $display("FAIL mid_flush: got valid=%b ready=%b want valid=0 ready=1", outs_valid, ins_ready); end
      checks++; if (mismatch !== 1'b0 || mismatch_count !== 16'd0 || token_count !== 16'd0) begin failures++; $display("FAIL mid_status: got mm=%b mc=%0d tc=%0d want 0 0 0", mismatch, mismatch_count, token_count); end
      e0 = obs_emits;
      outs_ready = 1'b1;
      repeat (3) step();
      checks++; if (obs_emits !== e0 || outs_valid !== 1'b0) begin failures++; $display("FAIL mid_spurious_emit: got %0d emits want 0", obs_emits - e0); end
      outs_ready = 1'b0;
   endtask

   task automatic test_saturation();
      do_reset(1);
      ins = 32'hDEAD_BEEF; ins_valid = 1'b1; outs_ready = 1'b1;
      repeat (20) step();
      ins_valid = 1'b0;
      step();
      checks++; if (s_token_count !== 4'd15 || 32'(s_token_count) != m_tok4) begin failures++; $display("FAIL sat_token_count: got %0d want 15", s_token_count); end
      checks++; if (s_mismatch_count !== 4'd15 || 32'(s_mismatch_count) != m_mc4) begin failures++; $display("FAIL sat_mismatch_count: got %0d want 15", s_mismatch_count); end
      checks++; if (token_count !== 16'd20 || mismatch_count !== 16'd20) begin failures++; $display("FAIL sat_wide_counts: got tc=%0d mc=%0d want 20 20", token_count, mismatch_count); end
      checks++; if (s_mismatch !== 1'b1) begin failures++; $display("FAIL sat_mismatch: got %b want 1", s_mismatch); end
      outs_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ins = '0; ins_valid = 1'b0; outs_ready = 1'b0;
      test_reset();
      test_single();
      test_backpressure();
      test_stream();
      test_mismatch();
      test_reset_mid();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
